// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one SRAM-like memory bus between the fetch stage (inst port) and
//   the MEM stage (data port). Only one transaction is outstanding at a time.
//   The data port has fixed priority. A starvation counter forces a fetch
//   grant after STARVE_LIMIT consecutive data grants taken while a fetch was
//   waiting.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   inst_req/inst_addr     fetch request (read, word size)
//   inst_addr_ok/data_ok   fetch handshake pulses, inst_rdata read data
//   data_req/wr/size/addr/wdata   MEM-stage request
//   data_addr_ok/data_ok   MEM handshake pulses, data_rdata read data
//   bus_req/wr/size/addr/wdata    registered request to the bus bridge
//   bus_addr_ok/data_ok/rdata     bus bridge responses
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
    typedef enum logic       {OWN_INST, OWN_DATA}     owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q,      state_d;
    owner_e      owner_q,      owner_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        bus_req_q,    bus_req_d;
    logic        bus_wr_q,     bus_wr_d;
    logic [1:0]  bus_size_q,   bus_size_d;
    logic [31:0] bus_addr_q,   bus_addr_d;
    logic [31:0] bus_wdata_q,  bus_wdata_d;

    logic grant_data;
    logic grant_inst;

    // Data wins unless a waiting fetch has already been passed over
    // STARVE_LIMIT times in a row.
    assign grant_data = data_req && !(inst_req && (starve_cnt_q == LIMIT));
    assign grant_inst = !grant_data && inst_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d     = S_ADDR;
                    owner_d     = OWN_DATA;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                    // Only count grants that actually bypassed a fetch.
                    if (!inst_req)
                        starve_cnt_d = 4'd0;
                    else if (starve_cnt_q != LIMIT)
                        starve_cnt_d = starve_cnt_q + 4'd1;
                end else if (grant_inst) begin
                    state_d      = S_ADDR;
                    owner_d      = OWN_INST;
                    bus_req_d    = 1'b1;
                    bus_wr_d     = 1'b0;
                    bus_size_d   = 2'd2;
                    bus_addr_d   = inst_addr;
                    bus_wdata_d  = 32'd0;
                    starve_cnt_d = 4'd0;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = S_DATA;
                    bus_req_d = 1'b0;
                end
            end
            S_DATA: begin
                if (bus_data_ok)
                    state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            starve_cnt_q <= 4'd0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_wr    = bus_wr_q;
    assign bus_size  = bus_size_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    // Bus acknowledgements are only honoured in the phase that expects them
    // and are steered to the current owner in the same cycle.
    logic addr_hit;
    logic data_hit;

    assign addr_hit = (state_q == S_ADDR) && bus_addr_ok;
    assign data_hit = (state_q == S_DATA) && bus_data_ok;

    assign inst_addr_ok = addr_hit && (owner_q == OWN_INST);
    assign data_addr_ok = addr_hit && (owner_q == OWN_DATA);
    assign inst_data_ok = data_hit && (owner_q == OWN_INST);
    assign data_data_ok = data_hit && (owner_q == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

endmodule
